vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder_if.sv | 26 ++
 rtl/vga_sync_decoder.sv | 165 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync-decoder bus: pixel strobe and raw syncs in, regenerated raster position and status out.
// Latency: none (signal bundle only).
// Backpressure: none; the source paces everything through pixelEn.
interface vga_sync_decoder_if;
    logic       pixelEn;
    logic       hSync;
    logic       vSync;
    logic [9:0] xIndex;
    logic [9:0] yIndex;
    logic       displayEnable;
    logic       locked;
    logic       frameStart;
    logic       syncError;

    // Sync source / capture side
    modport master (
        output pixelEn, hSync, vSync,
        input  xIndex, yIndex, displayEnable, locked, frameStart, syncError
    );

    // Decoder side
    modport slave (
        input  pixelEn, hSync, vSync,
        output xIndex, yIndex, displayEnable, locked, frameStart, syncError
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds raster counters from active-low hSync/vSync, checks line/frame periods, tracks lock.
// Latency: one pixel (decoder hCount equals the source hCount of the previous pixel).
// Backpressure: none; state moves only on pixelEn. VGA_SYNC_DECODER_PULSE_CHECK_EN adds sync width checks.
module vga_sync_decoder #(
    parameter int H_PIXELS    = 800,
    parameter int V_LINES     = 521,
    parameter int H_PULSE     = 96,
    parameter int V_PULSE     = 2,
    parameter int H_BACK      = 144,
    parameter int H_FRONT     = 784,
    parameter int V_BACK      = 31,
    parameter int V_FRONT     = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);
    localparam logic [9:0] H_LAST      = 10'(H_PIXELS - 1);
    localparam logic [9:0] V_LAST      = 10'(V_LINES - 1);
    localparam logic [9:0] H_BACK_C    = 10'(H_BACK);
    localparam logic [9:0] H_FRONT_C   = 10'(H_FRONT);
    localparam logic [9:0] V_BACK_C    = 10'(V_BACK);
    localparam logic [9:0] V_FRONT_C   = 10'(V_FRONT);
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

    // Elaboration guard: goodFrames is 4 bits and the sync pulses must end before the active region
    if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || H_PULSE >= H_BACK || V_PULSE >= V_BACK) begin : gBadCfg
        $error("vga_sync_decoder: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } lockState_t;

    lockState_t state;
    logic [3:0] goodFrames;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hPrev;
    logic       vPrev;
    logic       lockedReg;
    logic       frameStartReg;
    logic       syncErrorReg;

    logic hFall;
    logic hAtLast;
    logic lineBoundary;
    logic vFall;
    logic vAtLast;
    logic hPeriodErr;
    logic vPeriodErr;
    logic anyErr;

    assign hFall        = bus.pixelEn & hPrev & ~bus.hSync;
    assign hAtLast      = (hCount == H_LAST);
    assign lineBoundary = hFall | (bus.pixelEn & hAtLast);
    assign vFall        = lineBoundary & vPrev & ~bus.vSync;
    assign vAtLast      = (vCount == V_LAST);
    // An edge off the wrap point is early; a wrap with no edge is a missing edge
    assign hPeriodErr   = bus.pixelEn & (hFall != hAtLast);
    assign vPeriodErr   = lineBoundary & (vFall != vAtLast);

`ifdef VGA_SYNC_DECODER_PULSE_CHECK_EN
    localparam logic [9:0] H_PULSE_LAST = 10'(H_PULSE - 1);
    localparam logic [9:0] V_PULSE_LAST = 10'(V_PULSE - 1);
    logic hRise;
    logic hWidthErr;
    logic vWidthErr;
    assign hRise     = bus.pixelEn & ~hPrev & bus.hSync;
    assign hWidthErr = hRise & (hCount != H_PULSE_LAST);
    assign vWidthErr = lineBoundary & ~vPrev & bus.vSync & (vCount != V_PULSE_LAST);
    assign anyErr    = hPeriodErr | vPeriodErr | hWidthErr | vWidthErr;
`else
    assign anyErr    = hPeriodErr | vPeriodErr;
`endif

    // Horizontal counter: snap to 0 on the hSync falling edge, free-run and wrap otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hPrev  <= 1'b0;
            hCount <= '0;
        end else if (bus.pixelEn) begin
            hPrev <= bus.hSync;
            if (lineBoundary) begin
                hCount <= '0;
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    // Vertical counter: advances once per line boundary, snaps to 0 on the vSync falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vPrev  <= 1'b0;
            vCount <= '0;
        end else if (lineBoundary) begin
            vPrev <= bus.vSync;
            if (vFall || vAtLast) begin
                vCount <= '0;
            end else begin
                vCount <= vCount + 10'd1;
            end
        end
    end

    // Lock FSM with registered status; pulses are rewritten every clk so they never stretch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            goodFrames    <= '0;
            lockedReg     <= 1'b0;
            frameStartReg <= 1'b0;
            syncErrorReg  <= 1'b0;
        end else begin
            frameStartReg <= vFall;
            syncErrorReg  <= anyErr & (state != SEARCH);
            if (bus.pixelEn) begin
                case (state)
                    SEARCH: begin
                        if (vFall) begin
                            state      <= VERIFY;
                            goodFrames <= '0;
                        end
                    end
                    VERIFY: begin
                        if (anyErr) begin
                            state <= SEARCH;
                        end else if (vFall) begin
                            if (goodFrames + 4'd1 == LOCK_TARGET) begin
                                state     <= LOCKED;
                                lockedReg <= 1'b1;
                            end else begin
                                goodFrames <= goodFrames + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (anyErr) begin
                            state     <= SEARCH;
                            lockedReg <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        lockedReg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output indices are plain offsets of the counters, wrapping in 10 bits
    assign bus.xIndex        = hCount - H_BACK_C;
    assign bus.yIndex        = vCount - V_BACK_C;
    assign bus.displayEnable = lockedReg
                               & (vCount >= V_BACK_C) & (vCount < V_FRONT_C)
                               & (hCount >= H_BACK_C) & (hCount < H_FRONT_C);
    assign bus.locked        = lockedReg;
    assign bus.frameStart    = frameStartReg;
    assign bus.syncError     = syncErrorReg;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a scaled-down raster source drives the decoder; expectations are hand-derived.
// Latency: checks sample one clk after each pixel strobe edge.
// Backpressure: n/a; the bench owns pixelEn (one strobe every 4th clk).
module tb_vga_sync_decoder;
    // Small raster so whole frames fit a short run: 16 x 10, active x 4..13, y 3..7
    localparam int HP  = 16;
    localparam int VL  = 10;
    localparam int HPU = 2;
    localparam int VPU = 2;
    localparam int HB  = 4;
    localparam int HF  = 14;
    localparam int VB  = 3;
    localparam int VF  = 8;
    localparam int LF  = 2;

    logic clk;
    logic rst;

    vga_sync_decoder_if vga ();
    vga_sync_decoder_if vgaDflt ();

    vga_sync_decoder #(
        .H_PIXELS(HP), .V_LINES(VL), .H_PULSE(HPU), .V_PULSE(VPU),
        .H_BACK(HB), .H_FRONT(HF), .V_BACK(VB), .V_FRONT(VF), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vga)
    );

    // Default-timing instance, held idle, for the full-size reset values
    vga_sync_decoder dutDflt (
        .clk(clk),
        .rst(rst),
        .bus(vgaDflt)
    );
    assign vgaDflt.pixelEn = 1'b0;
    assign vgaDflt.hSync   = 1'b1;
    assign vgaDflt.vSync   = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;
    int sx, sy, lastX, lastY;
    int shortY = -1;
    int widenY = -1;
    bit stuckH = 1'b0;
    bit watchLock = 1'b0;
    int fsN = 0;
    int seN = 0;
    int badLock = 0;
    int base;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters and lock watch, sampled mid-cycle
    always @(negedge clk) begin
        if (vga.frameStart) fsN++;
        if (vga.syncError) seN++;
        if (watchLock && (vga.locked || vga.displayEnable)) badLock++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One source pixel: syncs from (sx,sy), one pixelEn clk, then advance the source raster
    task automatic stepPixel();
        int lowW;
        repeat (3) @(negedge clk);
        lowW = (sy == widenY) ? HPU + 1 : HPU;
        vga.hSync   = stuckH ? 1'b1 : !(sx < lowW);
        vga.vSync   = !(sy < VPU);
        vga.pixelEn = 1'b1;
        @(negedge clk);
        vga.pixelEn = 1'b0;
        lastX = sx;
        lastY = sy;
        if (sx == ((sy == shortY) ? HP - 2 : HP - 1)) begin
            sx = 0;
            sy = (sy == VL - 1) ? 0 : sy + 1;
        end else begin
            sx++;
        end
    endtask

    task automatic runTo(input int x, input int y);
        bit found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            stepPixel();
            found = (lastX == x) && (lastY == y);
        end
        checkVal("runTo_reached", found, 1);
    endtask

    task automatic stepUntilFs(input string tag, input logic expLocked);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            stepPixel();
            seen = vga.frameStart;
        end
        checkVal({tag, "_seen"}, seen, 1);
        checkVal({tag, "_locked"}, vga.locked, expLocked);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vga.pixelEn = 1'b0;
        vga.hSync = 1'b1;
        vga.vSync = 1'b1;
        sx = 0;
        sy = 0;
        repeat (2) @(negedge clk);
        checkVal("rst_xIndex", vga.xIndex, 1020);
        checkVal("rst_yIndex", vga.yIndex, 1021);
        checkVal("rst_de", vga.displayEnable, 0);
        checkVal("rst_locked", vga.locked, 0);
        checkVal("rst_fs", vga.frameStart, 0);
        checkVal("rst_se", vga.syncError, 0);
        checkVal("rst_dflt_xIndex", vgaDflt.xIndex, 880);
        checkVal("rst_dflt_yIndex", vgaDflt.yIndex, 993);
        rst = 1'b0;

        // Bring-up: lock on the third frameStart, no errors
        stepUntilFs("fs1", 1'b0);
        stepUntilFs("fs2", 1'b0);
        stepUntilFs("fs3", 1'b1);
        runTo(HP - 1, VL - 1);
        checkVal("bringup_no_err", seN, 0);
        checkVal("bringup_locked", vga.locked, 1);

        // Active-region edges
        runTo(HB, VB - 1);
        checkVal("act_above_de", vga.displayEnable, 0);
        checkVal("act_above_y", vga.yIndex, 1023);
        runTo(HB - 1, VB);
        checkVal("act_left_de", vga.displayEnable, 0);
        checkVal("act_left_x", vga.xIndex, 1023);
        runTo(HB, VB);
        checkVal("act_first_x", vga.xIndex, 0);
        checkVal("act_first_y", vga.yIndex, 0);
        checkVal("act_first_de", vga.displayEnable, 1);
        runTo(HF - 1, VF - 1);
        checkVal("act_last_de", vga.displayEnable, 1);
        checkVal("act_last_x", vga.xIndex, HF - 1 - HB);
        checkVal("act_last_y", vga.yIndex, VF - 1 - VB);
        runTo(HF, VF - 1);
        checkVal("act_right_de", vga.displayEnable, 0);
        runTo(HF - 1, VF);
        checkVal("act_below_de", vga.displayEnable, 0);

        // One short line: single error on the early hFall, relock after two clean frames
        runTo(HP - 1, 3);
        shortY = 4;
        base = seN;
        runTo(HP - 2, 4);
        shortY = -1;
        stepPixel();
        checkVal("short_se", vga.syncError, 1);
        checkVal("short_locked", vga.locked, 0);
        @(negedge clk);
        checkVal("short_se_one_clk", vga.syncError, 0);
        stepUntilFs("short_fs1", 1'b0);
        stepUntilFs("short_fs2", 1'b0);
        stepUntilFs("short_fs3", 1'b1);
        checkVal("short_err_count", seN - base, 1);

        // hSync low one pixel longer than nominal
        widenY = 5;
        base = seN;
        runTo(HPU + 1, 5);
        widenY = -1;
`ifdef VGA_SYNC_DECODER_PULSE_CHECK_EN
        checkVal("widen_se", vga.syncError, 1);
        checkVal("widen_locked", vga.locked, 0);
        stepUntilFs("widen_fs1", 1'b0);
        stepUntilFs("widen_fs2", 1'b0);
        stepUntilFs("widen_fs3", 1'b1);
        checkVal("widen_err_count", seN - base, 1);
`else
        checkVal("widen_se", vga.syncError, 0);
        checkVal("widen_locked", vga.locked, 1);
        stepUntilFs("widen_fs", 1'b1);
        checkVal("widen_err_count", seN - base, 0);
`endif

        // hSync stuck high: error at the first missed wrap, then once per frame after each re-entry to VERIFY
        runTo(HP - 1, 4);
        stuckH = 1'b1;
        base = seN;
        stepPixel();
        checkVal("stuck_se", vga.syncError, 1);
        checkVal("stuck_locked", vga.locked, 0);
        checkVal("stuck_de", vga.displayEnable, 0);
        watchLock = 1'b1;
        runTo(HP - 1, VL - 1);
        runTo(HP - 1, VL - 1);
        runTo(HP - 1, VL - 1);
        watchLock = 1'b0;
        checkVal("stuck_err_count", seN - base, 3);
        checkVal("stuck_never_locked", badLock, 0);
        stuckH = 1'b0;
        stepUntilFs("stuck_fs1", 1'b0);
        stepUntilFs("stuck_fs2", 1'b0);
        stepUntilFs("stuck_fs3", 1'b1);

        // Reset mid-line while hSync is low
        runTo(1, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("mid_rst_xIndex", vga.xIndex, 1020);
        checkVal("mid_rst_yIndex", vga.yIndex, 1021);
        checkVal("mid_rst_locked", vga.locked, 0);
        checkVal("mid_rst_de", vga.displayEnable, 0);
        @(negedge clk);
        rst = 1'b0;
        base = fsN;
        runTo(HP - 1, VL - 1);
        @(negedge clk);
        checkVal("mid_rst_no_fs", fsN - base, 0);
        stepPixel();
        checkVal("mid_rst_first_fs", vga.frameStart, 1);
        @(negedge clk);
        checkVal("mid_rst_fs_count", fsN - base, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
